// File: rtl/gray_to_binary_converter.sv
// Registered N-bit Gray-to-binary converter with a valid qualifier and a
// Gray-step integrity check that flags consecutive valid words differing in more than one bit.
module gray_to_binary_converter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] gray_in,
    output logic         out_valid,
    output logic [N-1:0] binary_out,
    output logic         step_err
);

    logic [N-1:0] bin_next;
    logic [N-1:0] prev_gray;
    logic         have_prev;
    logic [N-1:0] diff;
    logic         multi_bit;

    // b[i] is the XOR-reduction of g[N-1:i]
    always_comb begin
        bin_next = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bin_next[i] = ^(gray_in >> i);
        end
    end

    // popcount(diff) > 1 exactly when clearing the lowest set bit leaves something
    always_comb begin
        diff      = gray_in ^ prev_gray;
        multi_bit = |(diff & (diff - N'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_out <= '0;
            out_valid  <= 1'b0;
            step_err   <= 1'b0;
            prev_gray  <= '0;
            have_prev  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                binary_out <= bin_next;
                step_err   <= have_prev & multi_bit;
                prev_gray  <= gray_in;
                have_prev  <= 1'b1;
            end else begin
                step_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_binary_converter.sv
// Directed bench for gray_to_binary_converter at N = 4, 8 and 1 with
// hand-computed expectations checked by immediate assertions.
module tb_gray_to_binary_converter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v4 = 1'b0, v8 = 1'b0, v1 = 1'b0;
    logic [3:0] g4 = '0;
    logic [7:0] g8 = '0;
    logic [0:0] g1 = '0;
    logic       ov4, ov8, ov1, se4, se8, se1;
    logic [3:0] b4;
    logic [7:0] b8;
    logic [0:0] b1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] sweep_bin [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                                   4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
    // Hamming distance to the previous input is >1 at inputs 2,4,...,14
    logic [15:0] sweep_err = 16'b0101_0101_0101_0100;
    logic [3:0] gray_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    gray_to_binary_converter #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .gray_in(g4),
        .out_valid(ov4), .binary_out(b4), .step_err(se4));
    gray_to_binary_converter #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .gray_in(g8),
        .out_valid(ov8), .binary_out(b8), .step_err(se8));
    gray_to_binary_converter #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .gray_in(g1),
        .out_valid(ov1), .binary_out(b1), .step_err(se1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic ov, input logic [3:0] b, input logic se);
        chk({tag, "_ov"}, {7'd0, ov4}, {7'd0, ov});
        chk({tag, "_bin"}, {4'd0, b4}, {4'd0, b});
        chk({tag, "_err"}, {7'd0, se4}, {7'd0, se});
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        chk4("rst4", 1'b0, 4'd0, 1'b0);
        chk("rst8_bin", b8, 8'h00);
        chk("rst1_ov", {7'd0, ov1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exhaustive sweep 0..15
        for (int k = 0; k < 16; k++) begin
            v4 = 1'b1;
            g4 = 4'(k);
            tick();
            chk4($sformatf("sweep%0d", k), 1'b1, sweep_bin[k], sweep_err[k]);
        end
        v4 = 1'b0;
        pulse_reset();

        // True Gray count including wrap 1000 -> 0000
        tick();
        for (int k = 0; k < 17; k++) begin
            v4 = 1'b1;
            g4 = gray_seq[k];
            tick();
            chk4($sformatf("count%0d", k), 1'b1, 4'(k % 16), 1'b0);
        end
        v4 = 1'b0;
        pulse_reset();

        // Hold behaviour
        tick();
        v4 = 1'b1; g4 = 4'b0110;
        tick();
        chk4("hold_a", 1'b1, 4'd4, 1'b0);
        v4 = 1'b0; g4 = 4'b1111;
        tick(); chk4("hold_b", 1'b0, 4'd4, 1'b0);
        tick(); chk4("hold_c", 1'b0, 4'd4, 1'b0);
        tick(); chk4("hold_d", 1'b0, 4'd4, 1'b0);
        v4 = 1'b1; g4 = 4'b0110;
        tick();
        chk4("hold_e", 1'b1, 4'd4, 1'b0);
        v4 = 1'b0;
        pulse_reset();

        // Step violation then a legal step
        tick();
        v4 = 1'b1; g4 = 4'b0000;
        tick(); chk4("viol_a", 1'b1, 4'd0, 1'b0);
        g4 = 4'b0101;
        tick(); chk4("viol_b", 1'b1, 4'd6, 1'b1);
        v4 = 1'b0;
        tick(); chk4("viol_c", 1'b0, 4'd6, 1'b0);
        v4 = 1'b1; g4 = 4'b0100;
        tick(); chk4("viol_d", 1'b1, 4'd7, 1'b0);

        // Asynchronous reset mid-stream
        g4 = 4'b0001; tick();
        g4 = 4'b0011; tick();
        g4 = 4'b0010; tick();
        chk4("pre_rst", 1'b1, 4'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk4("async_rst", 1'b0, 4'd0, 1'b0);
        g4 = 4'b1010;
        tick();
        chk4("rst_ignored", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        g4 = 4'b1111;
        tick();
        chk4("post_rst", 1'b1, 4'd10, 1'b0);
        v4 = 1'b0;

        // Width scaling N = 8 and N = 1
        v8 = 1'b1; g8 = 8'h80;
        v1 = 1'b1; g1 = 1'b1;
        tick();
        chk("w8_a_bin", b8, 8'hFF);
        chk("w8_a_err", {7'd0, se8}, 8'h00);
        chk("w1_a_bin", {7'd0, b1}, 8'h01);
        g8 = 8'hFF; g1 = 1'b0;
        tick();
        chk("w8_b_bin", b8, 8'hAA);
        chk("w8_b_err", {7'd0, se8}, 8'h01);
        chk("w1_b_bin", {7'd0, b1}, 8'h00);
        chk("w1_b_err", {7'd0, se1}, 8'h00);
        g1 = 1'b1;
        tick();
        chk("w1_c_bin", {7'd0, b1}, 8'h01);
        chk("w1_c_err", {7'd0, se1}, 8'h00);
        v8 = 1'b0; v1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_converter.md
# gray_to_binary_converter

Registered, parameterised Gray-code to binary converter with a valid qualifier and a Gray-step integrity check. It is used at the receive side of Gray-coded counters and pointers, such as clock-domain-crossing FIFO pointers and rotary or position encoders. It converts each valid N-bit Gray word to natural binary with one cycle of latency. It also flags consecutive valid Gray words that differ in more than one bit.

## Interface
- N, default 4: data width in bits; legal range N >= 1.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  qualifies gray_in in this cycle.
- gray_in  input  N  Gray-coded word; MSB is bit N-1.
- out_valid  output  1  binary_out and step_err are valid this cycle.
- binary_out  output  N  binary equivalent of the gray_in captured one cycle earlier.
- step_err  output  1  pulse: the captured word differed from the previous valid word in more than one bit.

## Operation
- Conversion is defined as:
  - b[N-1] = g[N-1];
  - b[i] = b[i+1] XOR g[i], for i = N-2 down to 0.
  - Equivalently, b[i] is the XOR of g[N-1:i].
- The conversion is purely combinational on gray_in. Only the result is registered.
- Output register update:
  - on a cycle with in_valid = 1, binary_out is loaded with the converted value;
  - on a cycle with in_valid = 0, binary_out holds its last value.
- out_valid is a registered copy of in_valid.
- The block has no backpressure. The consumer must accept every out_valid cycle.
- Step checker:
  - internal register prev_gray (N bits) and flag have_prev (1 bit);
  - on each valid input, dist = popcount(gray_in XOR prev_gray);
  - step_err is registered as (have_prev AND dist > 1);
  - then prev_gray is loaded with gray_in and have_prev is set to 1.
- Step checker rules:
  - dist = 0 (repeated word) is legal;
  - dist = 1 is legal;
  - the wrap from the last code to the first code, e.g. 1000 -> 0000 for N = 4, is dist = 1 and therefore legal;
  - the first valid word after reset is never flagged.
- step_err is 0 in any cycle where out_valid = 0.
- N = 1: binary_out = gray_in, and step_err is always 0.

## Timing
- Latency: gray_in sampled at rising edge k appears on binary_out, out_valid and step_err after edge k, i.e. during cycle k+1.
- Throughput: one word per cycle; back-to-back valid inputs are supported.
- Reset:
  - rst_n low clears immediately, without waiting for a clock edge: binary_out = 0, out_valid = 0, step_err = 0, prev_gray = 0, have_prev = 0;
  - while rst_n is low, all inputs are ignored;
  - a reset in the middle of a stream discards the history; the next valid word is treated as the first.
- Reset release: the first capture occurs on the first rising edge after rst_n goes high.
- There are no combinational paths from any input to any output.

## Test plan
- Exhaustive sweep, N = 4: drive gray_in = 0..15 on consecutive valid cycles. Required binary_out sequence, one cycle later: 0, 1, 3, 2, 7, 6, 4, 5, 15, 14, 12, 13, 8, 9, 11, 10. step_err fires on the inputs whose Hamming distance from the previous word is greater than 1, e.g. 0001 -> 0010 (distance 2); the first input 0000 is never flagged.
- Gray-count stream, N = 4: feed the true Gray sequence 0000, 0001, 0011, 0010, 0110, ..., 1000, then wrap to 0000. Required: binary_out = 0, 1, 2, ..., 15, 0; step_err stays 0 throughout, including at the wrap.
- Hold behaviour: valid 0110, then in_valid = 0 for 3 cycles, then valid 0110. Required: binary_out stays 0100 (4) throughout; out_valid toggles 1, 0, 0, 0, 1; step_err = 0.
- Step violation: valid 0000 then valid 0101. Required: second output has binary_out = 0110 (6) and step_err = 1 for exactly one cycle.
- Asynchronous reset mid-stream: after several valid words, pull rst_n low between clock edges. Required: all outputs go to 0 immediately. After release, valid 1111 produces binary_out = 1010 (10) with step_err = 0.
- Width scaling: with N = 8, input 8'b1000_0000 gives 8'hFF; input 8'hFF gives 8'hAA. With N = 1, the output equals the input.
